// File: rtl/vip_video_stream_gen_if.sv
// Pixel-memory read port and timed video output of the stream generator.
// The master side is the generator; the slave side is the memory/sink.
interface vip_video_stream_gen_if #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 18
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              frame_vsync;
  logic              frame_href;
  logic              frame_clken;
  logic [DATA_W-1:0] pix_data;

  modport master (
    output rd_en, rd_addr,
    input  rd_data,
    output frame_vsync, frame_href, frame_clken, pix_data
  );

  modport slave (
    input  rd_en, rd_addr,
    output rd_data,
    input  frame_vsync, frame_href, frame_clken, pix_data
  );
endinterface

// File: rtl/vip_video_stream_gen.sv
// Video timing generator: scans a frame from pixel memory and emits
// vsync/href/clken/pixel aligned three cycles after the scan counters.
module vip_video_stream_gen #(
  parameter int unsigned IMG_HDISP = 400,
  parameter int unsigned IMG_VDISP = 400,
  parameter int unsigned H_SYNC    = 5,
  parameter int unsigned H_BACK    = 5,
  parameter int unsigned H_FRONT   = 5,
  parameter int unsigned V_SYNC    = 1,
  parameter int unsigned V_BACK    = 0,
  parameter int unsigned V_FRONT   = 1,
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned PIX_DIV   = 1,
  parameter int unsigned ADDR_W    = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  continuous,
  vip_video_stream_gen_if.master vid,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_cnt
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + IMG_HDISP + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + IMG_VDISP + V_FRONT;

  localparam logic [15:0] H_LAST     = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST     = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_ACT_LO   = 16'(H_SYNC + H_BACK);
  localparam logic [15:0] H_ACT_HI   = 16'(H_SYNC + H_BACK + IMG_HDISP);
  localparam logic [15:0] V_ACT_LO   = 16'(V_SYNC + V_BACK);
  localparam logic [15:0] V_ACT_HI   = 16'(V_SYNC + V_BACK + IMG_VDISP);
  localparam logic [15:0] V_SYNC_END = 16'(V_SYNC);
  localparam logic [3:0]  DIV_LAST   = 4'(PIX_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e            state_q;
  logic [3:0]        div_q;
  logic [15:0]       hcnt_q;
  logic [15:0]       vcnt_q;
  logic [ADDR_W-1:0] pix_idx_q;
  logic              busy_q;

  logic              s1_tick_q, s1_act_q, s1_vs_q, s1_end_q;
  logic              s2_tick_q, s2_act_q, s2_vs_q, s2_end_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              vsync_q, href_q, clken_q;
  logic [DATA_W-1:0] pix_data_q;
  logic              frame_done_q;
  logic [15:0]       frame_cnt_q;

  logic tick, active, line_end, frame_end;

  always_comb begin
    tick      = (state_q == RUN) && (div_q == DIV_LAST);
    active    = (hcnt_q >= H_ACT_LO) && (hcnt_q < H_ACT_HI) &&
                (vcnt_q >= V_ACT_LO) && (vcnt_q < V_ACT_HI);
    line_end  = (hcnt_q == H_LAST);
    frame_end = tick && line_end && (vcnt_q == V_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      pix_idx_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= RUN;
            busy_q    <= 1'b1;
            div_q     <= '0;
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            pix_idx_q <= '0;
          end
        end
        RUN: begin
          div_q <= (div_q == DIV_LAST) ? '0 : div_q + 4'd1;
          if (tick) begin
            if (active) pix_idx_q <= pix_idx_q + 1'b1;
            if (line_end) begin
              hcnt_q <= '0;
              vcnt_q <= (vcnt_q == V_LAST) ? '0 : vcnt_q + 16'd1;
            end else begin
              hcnt_q <= hcnt_q + 16'd1;
            end
            if (frame_end) begin
              pix_idx_q <= '0;
              if (!continuous) begin
                state_q <= DRAIN;
                div_q   <= '0;
              end
            end
          end
        end
        DRAIN: begin
          if (frame_done_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // href/vsync change only on delayed ticks, so each pixel's href interval
  // starts with its clken pulse and lasts PIX_DIV cycles with stable data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_tick_q    <= 1'b0;
      s1_act_q     <= 1'b0;
      s1_vs_q      <= 1'b0;
      s1_end_q     <= 1'b0;
      s2_tick_q    <= 1'b0;
      s2_act_q     <= 1'b0;
      s2_vs_q      <= 1'b0;
      s2_end_q     <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      clken_q      <= 1'b0;
      pix_data_q   <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      s1_tick_q <= tick;
      s1_act_q  <= active;
      s1_vs_q   <= (vcnt_q >= V_SYNC_END);
      s1_end_q  <= frame_end;
      rd_en_q   <= tick && active;
      if (tick && active) rd_addr_q <= pix_idx_q;

      s2_tick_q <= s1_tick_q;
      s2_act_q  <= s1_act_q;
      s2_vs_q   <= s1_vs_q;
      s2_end_q  <= s1_end_q;

      clken_q      <= s2_tick_q;
      frame_done_q <= s2_tick_q && s2_end_q;
      if (s2_tick_q) begin
        href_q  <= s2_act_q;
        vsync_q <= s2_vs_q;
        if (s2_act_q) pix_data_q <= vid.rd_data;
        if (s2_end_q) frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if ((state_q == DRAIN) && frame_done_q) begin
        href_q  <= 1'b0;
        vsync_q <= 1'b0;
      end
    end
  end

  assign vid.rd_en       = rd_en_q;
  assign vid.rd_addr     = rd_addr_q;
  assign vid.frame_vsync = vsync_q;
  assign vid.frame_href  = href_q;
  assign vid.frame_clken = clken_q;
  assign vid.pix_data    = pix_data_q;
  assign busy            = busy_q;
  assign frame_done      = frame_done_q;
  assign frame_cnt       = frame_cnt_q;

endmodule

// File: tb/tb_vip_video_stream_gen.sv
// Bench for vip_video_stream_gen: two instances (PIX_DIV 1 and 3) on a 4x3
// image, checked cycle by cycle against an arithmetic timing model.
module tb_vip_video_stream_gen;

  localparam int HD = 4;
  localparam int VD = 3;
  localparam int HOFF = 2;
  localparam int VOFF = 1;
  localparam int HT = 7;
  localparam int VT = 5;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       continuous;
  logic [1:0] start;
  logic [1:0] busy;
  logic [1:0] done;
  logic [15:0] fcnt0, fcnt1;

  always #5 clk = ~clk;

  vip_video_stream_gen_if #(.DATA_W(24), .ADDR_W(18)) vif0 ();
  vip_video_stream_gen_if #(.DATA_W(24), .ADDR_W(18)) vif1 ();

  vip_video_stream_gen #(
    .IMG_HDISP(HD), .IMG_VDISP(VD), .H_SYNC(1), .H_BACK(1), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(0), .V_FRONT(1), .DATA_W(24), .PIX_DIV(1), .ADDR_W(18)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .continuous(continuous),
    .vid(vif0), .busy(busy[0]), .frame_done(done[0]), .frame_cnt(fcnt0)
  );

  vip_video_stream_gen #(
    .IMG_HDISP(HD), .IMG_VDISP(VD), .H_SYNC(1), .H_BACK(1), .H_FRONT(1),
    .V_SYNC(1), .V_BACK(0), .V_FRONT(1), .DATA_W(24), .PIX_DIV(3), .ADDR_W(18)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .continuous(continuous),
    .vid(vif1), .busy(busy[1]), .frame_done(done[1]), .frame_cnt(fcnt1)
  );

  // Pixel memory: one-cycle read latency, content equals address.
  always @(posedge clk) begin
    if (vif0.rd_en) vif0.rd_data <= 24'(vif0.rd_addr);
    if (vif1.rd_en) vif1.rd_data <= 24'(vif1.rd_addr);
  end

  logic        ob_vs [2];
  logic        ob_hr [2];
  logic        ob_ck [2];
  logic        ob_re [2];
  logic [17:0] ob_ad [2];
  logic [23:0] ob_px [2];
  logic [15:0] ob_fc [2];

  assign ob_vs[0] = vif0.frame_vsync;
  assign ob_vs[1] = vif1.frame_vsync;
  assign ob_hr[0] = vif0.frame_href;
  assign ob_hr[1] = vif1.frame_href;
  assign ob_ck[0] = vif0.frame_clken;
  assign ob_ck[1] = vif1.frame_clken;
  assign ob_re[0] = vif0.rd_en;
  assign ob_re[1] = vif1.rd_en;
  assign ob_ad[0] = vif0.rd_addr;
  assign ob_ad[1] = vif1.rd_addr;
  assign ob_px[0] = vif0.pix_data;
  assign ob_px[1] = vif1.pix_data;
  assign ob_fc[0] = fcnt0;
  assign ob_fc[1] = fcnt1;

  int n_cmp = 0;
  int n_bad = 0;
  int fc_base [2];
  int last_pix [2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit is_act(input int h, input int v);
    return (h >= HOFF) && (h < HOFF + HD) && (v >= VOFF) && (v < VOFF + VD);
  endfunction

  // Expected outputs for cycle t after start of a run of nf frames.
  task automatic check_cycle(input int sel, input int t, input int nf);
    int P, ftp, cd, u, w, kk, pos, h, v, nd, e_ad, e_fc;
    logic e_vs, e_hr, e_ck, e_re, e_dn, e_by;
    string s;
    P = (sel == 0) ? 1 : 3;
    ftp = FT * P;
    cd = nf * ftp + 2;
    e_vs = 0; e_hr = 0; e_ck = 0; e_re = 0; e_dn = 0; e_by = 0; e_ad = 0;
    if (t <= cd) begin
      e_by = 1;
      u = t - 3;
      if (u >= 0 && u + 1 >= P) begin
        kk = (u + 1) / P - 1;
        pos = kk % FT; h = pos % HT; v = pos / HT;
        e_hr = is_act(h, v);
        e_vs = (v >= 1);
        e_ck = ((u + 1) % P == 0);
        if (e_ck && e_hr) last_pix[sel] = (v - VOFF) * HD + (h - HOFF);
        e_dn = e_ck && (pos == FT - 1);
      end
      w = t - 1;
      if (w >= 0 && (w + 1) % P == 0) begin
        kk = (w + 1) / P - 1;
        if (kk < nf * FT) begin
          pos = kk % FT; h = pos % HT; v = pos / HT;
          e_re = is_act(h, v);
          e_ad = (v - VOFF) * HD + (h - HOFF);
        end
      end
    end
    nd = (t >= 2) ? (t - 2) / ftp : 0;
    if (nd > nf) nd = nf;
    e_fc = (fc_base[sel] + nd) % 65536;
    s = $sformatf("d%0d t%0d", sel, t);
    check_val({"vsync ", s}, 32'(ob_vs[sel]), 32'(e_vs));
    check_val({"href ", s}, 32'(ob_hr[sel]), 32'(e_hr));
    check_val({"clken ", s}, 32'(ob_ck[sel]), 32'(e_ck));
    check_val({"rd_en ", s}, 32'(ob_re[sel]), 32'(e_re));
    if (e_re) check_val({"rd_addr ", s}, 32'(ob_ad[sel]), 32'(e_ad));
    check_val({"pix ", s}, 32'(ob_px[sel]), 32'(last_pix[sel]));
    check_val({"done ", s}, 32'(done[sel]), 32'(e_dn));
    check_val({"busy ", s}, 32'(busy[sel]), 32'(e_by));
    check_val({"fcnt ", s}, 32'(ob_fc[sel]), 32'(e_fc));
  endtask

  task automatic check_zero(input int sel);
    string s;
    s = $sformatf("reset d%0d", sel);
    check_val({"vsync ", s}, 32'(ob_vs[sel]), 32'd0);
    check_val({"href ", s}, 32'(ob_hr[sel]), 32'd0);
    check_val({"clken ", s}, 32'(ob_ck[sel]), 32'd0);
    check_val({"rd_en ", s}, 32'(ob_re[sel]), 32'd0);
    check_val({"rd_addr ", s}, 32'(ob_ad[sel]), 32'd0);
    check_val({"pix ", s}, 32'(ob_px[sel]), 32'd0);
    check_val({"done ", s}, 32'(done[sel]), 32'd0);
    check_val({"busy ", s}, 32'(busy[sel]), 32'd0);
    check_val({"fcnt ", s}, 32'(ob_fc[sel]), 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        check_val($sformatf("idle busy d%0d", d), 32'(busy[d]), 32'd0);
        check_val($sformatf("idle vsync d%0d", d), 32'(ob_vs[d]), 32'd0);
        check_val($sformatf("idle href d%0d", d), 32'(ob_hr[d]), 32'd0);
        check_val($sformatf("idle clken d%0d", d), 32'(ob_ck[d]), 32'd0);
        check_val($sformatf("idle rd_en d%0d", d), 32'(ob_re[d]), 32'd0);
        check_val($sformatf("idle pix d%0d", d), 32'(ob_px[d]), 32'(last_pix[d]));
        check_val($sformatf("idle fcnt d%0d", d), 32'(ob_fc[d]), 32'(fc_base[d] % 65536));
      end
    end
  endtask

  // nfr frames (continuous held high at every frame end but the last);
  // optional ignored start pulse at cycle mid_start, optional reset at rst_at.
  task automatic run_frames(input int sel, input int nfr, input int mid_start, input int rst_at);
    int t, nf, P, limit;
    bit finished;
    P = (sel == 0) ? 1 : 3;
    nf = 1;
    t = 0;
    limit = nfr * FT * P + 20;
    finished = 0;
    continuous = (nfr > 1);
    start[sel] = 1'b1;
    @(posedge clk); #1;
    start[sel] = 1'b0;
    while (!finished && t < limit) begin
      if (t > 0) begin
        @(posedge clk); #1;
      end
      check_cycle(sel, t, nf);
      if (t == rst_at) begin
        rst_n = 1'b0;
        #1;
        fc_base[0] = 0; fc_base[1] = 0;
        last_pix[0] = 0; last_pix[1] = 0;
        check_zero(0);
        check_zero(1);
        start = '0;
        continuous = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        return;
      end
      if (t >= nf * FT * P + 4) finished = 1;
      start[sel] = (t == mid_start);
      if (((t + 1) % (FT * P) == 0) && ((t + 1) / (FT * P) == nf)) begin
        continuous = (nf < nfr);
        if (continuous) nf++;
      end else begin
        continuous = 1'($urandom);
      end
      t++;
    end
    start[sel] = 1'b0;
    continuous = 1'b0;
    check_val($sformatf("run_complete d%0d", sel), 32'(finished), 32'd1);
    fc_base[sel] += nf;
  endtask

  initial begin
    start = '0;
    continuous = 1'b0;
    rst_n = 1'b0;
    fc_base[0] = 0; fc_base[1] = 0;
    last_pix[0] = 0; last_pix[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    check_zero(0);
    check_zero(1);
    rst_n = 1'b1;
    idle_cycles(4);

    run_frames(0, 1, -1, -1);
    idle_cycles(int'($urandom_range(1, 4)));
    run_frames(0, 4, int'($urandom_range(5, 120)), -1);
    idle_cycles(2);
    run_frames(1, int'($urandom_range(1, 2)), int'($urandom_range(5, 90)), -1);
    idle_cycles(2);
    run_frames(0, 1, int'($urandom_range(5, 30)), -1);
    run_frames(0, 2, -1, 20);
    idle_cycles(3);
    run_frames(0, 1, -1, -1);
    for (int i = 0; i < 3; i++) begin
      run_frames(int'($urandom_range(0, 1)), int'($urandom_range(1, 2)),
                 int'($urandom_range(5, 60)), -1);
      idle_cycles(int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
